tt_pin_exerciser: RTL
=====================

Name: tt_pin_exerciser

Overview:
- Host-side counterpart of a TinyTapeout user design. It sits on the opposite side of the ui/uo/uio pin interface.
- Sequences the user design's reset and enable, then drives pseudo-random vectors onto ui_in/uio_in.
- Compresses uo_out and the enabled uio_out bits into a 16-bit MISR signature.
- Used on the bench and on the FPGA harness for go/no-go checks of user designs.

Parameters:
- RESET_CYCLES, 10, cycles dut_rst_n is held low after start (1..255)
- VECTOR_COUNT, 256, vectors applied per run (1..65535)
- SETTLE_CYCLES, 1, cycles between driving a vector and capturing the response (0..15)
- LFSR_SEED, 8'hA5, initial stimulus value; 8'h00 is replaced by 8'h01

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- start  in  1  single-cycle run request
- busy  out  1  high from the cycle after start until done
- done  out  1  high from run end until the next start or rst
- signature  out  16  MISR result; valid while done=1
- vec_count  out  16  vectors captured so far in this run
- dut_rst_n  out  1  reset to the user design, active low
- dut_ena  out  1  enable to the user design
- dut_ui_in  out  8  stimulus
- dut_uio_in  out  8  stimulus on bidirectional inputs
- dut_uo_out  in  8  user design outputs
- dut_uio_out  in  8  user design bidirectional outputs
- dut_uio_oe  in  8  user design bidirectional output enables

Behaviour:
- Single clk domain. rst is asynchronous and active-high.
- On rst:
  - state=IDLE, busy=0, done=0, signature=0, vec_count=0
  - dut_rst_n=0, dut_ena=0, dut_ui_in=0, dut_uio_in=0
  - LFSR=LFSR_SEED
- All outputs are registered.
- FSM states: IDLE, RESET, DRIVE, SETTLE, CAPTURE, DONE.
- IDLE:
  - dut_rst_n=0.
  - On start=1: go to RESET next cycle, busy=1, dut_ena=1.
  - Clear signature and vec_count, reload the LFSR with the seed.
- RESET:
  - dut_rst_n=0 for exactly RESET_CYCLES cycles, counted from RESET entry.
  - Then dut_rst_n=1 and go to DRIVE.
- DRIVE (1 cycle):
  - dut_ui_in<=LFSR.
  - dut_uio_in<={LFSR[3:0],LFSR[7:4]}.
  - Go to SETTLE, or to CAPTURE if SETTLE_CYCLES=0.
- SETTLE: wait SETTLE_CYCLES cycles, then go to CAPTURE.
- CAPTURE (1 cycle):
  - Sample the DUT inputs and update the MISR.
  - vec_count+=1, advance the LFSR.
  - If vec_count reaches VECTOR_COUNT: go to DONE. Otherwise go to DRIVE.
- One vector therefore takes SETTLE_CYCLES+2 cycles.
- LFSR (Fibonacci): next = {q[6:0], q[7]^q[5]^q[4]^q[3]}.
- MISR (CRC-CCITT form):
  - s' = (s<<1) ^ (s[15] ? 16'h1021 : 0) ^ D
  - D = {dut_uio_out & dut_uio_oe, dut_uo_out}, bits 15:8 from uio, 7:0 from uo.
- DONE:
  - busy=0, done=1, signature held.
  - dut_ena stays 1, dut_rst_n stays 1, stimulus held.
  - start=1 in DONE begins a new run exactly as from IDLE, and done clears.
- start while busy=1 is ignored.
- rst mid-run: immediate return to reset values. No partial signature is retained.
- vec_count saturates at VECTOR_COUNT and never wraps.

Optional Feature:
- Macro: TT_PIN_EXERCISER_COMPARE_EN.
- With the macro defined:
  - Adds parameter EXPECTED_SIG (default 16'h0000).
  - Adds output pass (1 bit, reset 0).
  - pass is registered high in the cycle done rises if signature==EXPECTED_SIG, else 0.
  - pass is cleared on start.
- Without the macro: no EXPECTED_SIG parameter, no pass port, no compare logic.

Test Plan:
- Reset/enable sequence: rst, then start pulse with RESET_CYCLES=10 -> dut_ena=1 and dut_rst_n=0 for exactly 10 cycles, then 1; busy=1 throughout.
- Single vector: loopback DUT (uo_out=ui_in, uio_oe=0), VECTOR_COUNT=1, seed A5 -> dut_ui_in=8'hA5, signature=16'h00A5, vec_count=1, done=1.
- Two vectors: same setup, VECTOR_COUNT=2 -> second vector 8'h4A, signature=16'h0100, completion 10+2*(SETTLE_CYCLES+2) cycles after RESET entry.
- uio masking: DUT drives uio_out=8'hFF with uio_oe=8'h0F and uo_out=0, VECTOR_COUNT=1 -> signature=16'h0F00.
- Control edges:
  - start while busy -> ignored, run length unchanged.
  - rst asserted mid-CAPTURE -> all outputs at reset values the same cycle.
  - start in DONE -> new run, signature reproduced.
- Compare (macro defined): EXPECTED_SIG=16'h00A5 with the single-vector setup -> pass=1; EXPECTED_SIG=16'h1234 -> pass=0.

Source files
------------

// File: rtl/tt_pin_exerciser.sv
// tt_pin_exerciser: host-side driver for a TinyTapeout user design.
// Releases the design from reset, applies LFSR stimulus on ui/uio and folds
// uo_out plus the enabled uio_out bits into a 16-bit MISR signature.
// Optional build macro TT_PIN_EXERCISER_COMPARE_EN adds EXPECTED_SIG and a
// registered pass flag comparing the final signature against it.
module tt_pin_exerciser #(
  parameter int unsigned RESET_CYCLES  = 10,
  parameter int unsigned VECTOR_COUNT  = 256,
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter logic [7:0]  LFSR_SEED     = 8'hA5
`ifdef TT_PIN_EXERCISER_COMPARE_EN
  , parameter logic [15:0] EXPECTED_SIG = 16'h0000
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [15:0] signature,
  output logic [15:0] vec_count,
  output logic        dut_rst_n,
  output logic        dut_ena,
  output logic [7:0]  dut_ui_in,
  output logic [7:0]  dut_uio_in,
  input  logic [7:0]  dut_uo_out,
  input  logic [7:0]  dut_uio_out,
  input  logic [7:0]  dut_uio_oe
`ifdef TT_PIN_EXERCISER_COMPARE_EN
  , output logic      pass
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    RESET,
    DRIVE,
    SETTLE,
    CAPTURE,
    DONE
  } state_t;

  // An all-zero seed would lock the LFSR, so it is swapped for 1.
  localparam logic [7:0]  SEED        = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
  localparam logic [7:0]  RESET_LAST  = 8'(RESET_CYCLES - 1);
  localparam logic [7:0]  SETTLE_LAST = 8'((SETTLE_CYCLES == 0) ? 0 : SETTLE_CYCLES - 1);
  localparam logic [15:0] VEC_TOTAL   = 16'(VECTOR_COUNT);

  state_t      state;
  logic [7:0]  cnt;
  logic [7:0]  lfsr;
  logic [7:0]  lfsr_next;
  logic [15:0] cap_data;
  logic [15:0] misr_next;
  logic        last_vec;

  // Next stimulus word, captured response word and next signature.
  always_comb begin
    lfsr_next = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    cap_data  = {dut_uio_out & dut_uio_oe, dut_uo_out};
    misr_next = {signature[14:0], 1'b0} ^ (signature[15] ? 16'h1021 : 16'h0000) ^ cap_data;
    last_vec  = ((vec_count + 16'd1) == VEC_TOTAL);
  end

  // Run sequencer: reset/enable the user design, then drive, settle, capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 8'd0;
      lfsr       <= SEED;
      busy       <= 1'b0;
      done       <= 1'b0;
      signature  <= 16'h0000;
      vec_count  <= 16'h0000;
      dut_rst_n  <= 1'b0;
      dut_ena    <= 1'b0;
      dut_ui_in  <= 8'h00;
      dut_uio_in <= 8'h00;
`ifdef TT_PIN_EXERCISER_COMPARE_EN
      pass       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (state == IDLE) begin
            dut_rst_n <= 1'b0;
          end
          if (start) begin
            state     <= RESET;
            cnt       <= 8'd0;
            lfsr      <= SEED;
            busy      <= 1'b1;
            done      <= 1'b0;
            signature <= 16'h0000;
            vec_count <= 16'h0000;
            dut_rst_n <= 1'b0;
            dut_ena   <= 1'b1;
`ifdef TT_PIN_EXERCISER_COMPARE_EN
            pass      <= 1'b0;
`endif
          end
        end
        RESET: begin
          if (cnt == RESET_LAST) begin
            cnt       <= 8'd0;
            dut_rst_n <= 1'b1;
            state     <= DRIVE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        DRIVE: begin
          dut_ui_in  <= lfsr;
          dut_uio_in <= {lfsr[3:0], lfsr[7:4]};
          cnt        <= 8'd0;
          state      <= (SETTLE_CYCLES == 0) ? CAPTURE : SETTLE;
        end
        SETTLE: begin
          if (cnt == SETTLE_LAST) begin
            cnt   <= 8'd0;
            state <= CAPTURE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        CAPTURE: begin
          signature <= misr_next;
          lfsr      <= lfsr_next;
          if (vec_count != VEC_TOTAL) begin
            vec_count <= vec_count + 16'd1;
          end
          if (last_vec) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
`ifdef TT_PIN_EXERCISER_COMPARE_EN
            pass  <= (misr_next == EXPECTED_SIG);
`endif
          end else begin
            state <= DRIVE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
